// File: rtl/xbar_defs_pkg.sv
// rtl/xbar_defs_pkg.sv - shared crossbar state codes, command codes and bus width
// Shared by master_tracker and data_seeker so the stat encoding stays consistent.
package xbar_defs_pkg;

    localparam int BUS_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W_GRANT = 2'd1,
        W_ACK   = 2'd2,
        W_DATA  = 2'd3
    } xbar_state_t;

    function automatic logic is_wait_state(input xbar_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/xbar_watchdog.sv
// rtl/xbar_watchdog.sv - wait-state watchdog counter with clear, enable and expire
// o_expire is combinational so the owner can give an advancing event priority in the same cycle.
module xbar_watchdog #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/master_tracker.sv
// rtl/master_tracker.sv - per-master transaction tracker for the 2x2 interconnect
// Latches one master request, walks it through grant/ack/data waits, aborts on watchdog expiry.
module master_tracker
    import xbar_defs_pkg::*;
#(
    parameter int SEL_BIT = 31,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_req,
    input  logic             m_cmd,
    input  logic [BUS_W-1:0] m_addr,
    input  logic [BUS_W-1:0] m_wdata,
    output logic             m_ack,
    output logic             m_err,
    output logic [BUS_W-1:0] m_rdata,
    input  logic             grant,
    output logic             s_req,
    output logic             s_cmd,
    output logic [BUS_W-1:0] s_addr,
    output logic [BUS_W-1:0] s_wdata,
    input  logic             s_ack,
    output logic [1:0]       stat,
    output logic             slave_sel,
    input  logic             data_read,
    input  logic [BUS_W-1:0] rdata_in
);

    xbar_state_t      r_state;
    logic             r_s_req;
    logic             r_s_cmd;
    logic [BUS_W-1:0] r_s_addr;
    logic [BUS_W-1:0] r_s_wdata;
    logic             r_slave_sel;
    logic             r_m_ack;
    logic             r_m_err;
    logic [BUS_W-1:0] r_m_rdata;

    logic w_accept;
    logic w_advance;
    logic w_expire;
    logic w_wd_enable;
    logic w_wd_clear;

    // The registered m_ack guard stops a held m_req from being re-accepted in the ack cycle.
    assign w_accept = (r_state == IDLE) && m_req && !r_m_ack;

    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            IDLE:    w_advance = w_accept;
            W_GRANT: w_advance = grant;
            W_ACK:   w_advance = s_ack;
            W_DATA:  w_advance = data_read;
            default: w_advance = 1'b0;
        endcase
    end

    assign w_wd_enable = is_wait_state(r_state);
    assign w_wd_clear  = w_advance || w_expire;

    xbar_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_s_req     <= 1'b0;
            r_s_cmd     <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_slave_sel <= 1'b0;
            r_m_ack     <= 1'b0;
            r_m_err     <= 1'b0;
            r_m_rdata   <= '0;
        end else begin
            r_m_ack   <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= W_GRANT;
                        r_s_cmd     <= m_cmd;
                        r_s_addr    <= m_addr;
                        r_s_wdata   <= m_wdata;
                        r_slave_sel <= m_addr[SEL_BIT];
                    end
                end
                W_GRANT: begin
                    if (grant) begin
                        r_state <= W_ACK;
                        r_s_req <= 1'b1;
                    end else if (w_expire) begin
                        r_state <= IDLE;
                        r_m_ack <= 1'b1;
                        r_m_err <= 1'b1;
                    end
                end
                W_ACK: begin
                    if (s_ack) begin
                        r_s_req <= 1'b0;
                        if (r_s_cmd == CMD_WRITE) begin
                            r_state <= IDLE;
                            r_m_ack <= 1'b1;
                        end else begin
                            r_state <= W_DATA;
                        end
                    end else if (w_expire) begin
                        r_state <= IDLE;
                        r_s_req <= 1'b0;
                        r_m_ack <= 1'b1;
                        r_m_err <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (data_read) begin
                        r_state   <= IDLE;
                        r_m_ack   <= 1'b1;
                        r_m_rdata <= rdata_in;
                    end else if (w_expire) begin
                        r_state <= IDLE;
                        r_m_ack <= 1'b1;
                        r_m_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_s_req <= 1'b0;
                end
            endcase
        end
    end

    assign m_ack     = r_m_ack;
    assign m_err     = r_m_err;
    assign m_rdata   = r_m_rdata;
    assign s_req     = r_s_req;
    assign s_cmd     = r_s_cmd;
    assign s_addr    = r_s_addr;
    assign s_wdata   = r_s_wdata;
    assign slave_sel = r_slave_sel;
    assign stat      = r_state;

endmodule

// File: tb/tb_master_tracker.sv
// tb/tb_master_tracker.sv - self-checking bench for master_tracker
// Each transaction's timeline is predicted from its grant/ack/data delays, then checked cycle by cycle.
module tb_master_tracker;

    localparam int T = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req, m_cmd;
    logic [31:0] m_addr, m_wdata;
    logic        m_ack, m_err;
    logic [31:0] m_rdata;
    logic        grant;
    logic        s_req, s_cmd;
    logic [31:0] s_addr, s_wdata;
    logic        s_ack;
    logic [1:0]  stat;
    logic        slave_sel;
    logic        data_read;
    logic [31:0] rdata_in;

    int total = 0;
    int bad   = 0;

    master_tracker #(.SEL_BIT(31), .CNT_W(8), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .grant(grant), .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .stat(stat), .slave_sel(slave_sel),
        .data_read(data_read), .rdata_in(rdata_in)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {27'd0, stat, s_req, m_ack, m_err}, 32'd0);
        check({tag, "_lat"}, {30'd0, s_cmd, slave_sel}, 32'd0);
        check({tag, "_addr"}, s_addr, 32'd0);
        check({tag, "_wdata"}, s_wdata, 32'd0);
        check({tag, "_rdata"}, m_rdata, 32'd0);
    endtask

    // g/a/d: cycles spent in W_GRANT/W_ACK/W_DATA before the advancing pulse; >= T means never.
    task automatic run_txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int g, input int a, input int d,
                           input logic keep);
        int          e1, e2, endk;
        logic        err;
        logic [31:0] exp_rd;
        logic [1:0]  st;
        err    = 1'b0;
        exp_rd = 32'd0;
        if (g >= T) begin
            e1 = T; e2 = T; endk = T; err = 1'b1;
        end else begin
            e1 = g + 1;
            if (a >= T) begin
                endk = e1 + T; e2 = endk; err = 1'b1;
            end else begin
                e2 = e1 + a + 1;
                if (cmd == 1'b1) endk = e2;
                else if (d >= T) begin endk = e2 + T; err = 1'b1; end
                else begin endk = e2 + d + 1; exp_rd = rdata; end
            end
        end
        m_req = 1'b1; m_cmd = cmd; m_addr = addr; m_wdata = wdata; rdata_in = rdata;
        for (int k = 0; k <= endk; k++) begin
            step();
            if (k < endk) begin
                st = (k < e1) ? 2'd1 : (k < e2) ? 2'd2 : 2'd3;
                check("cycle", {27'd0, stat, s_req, m_ack, m_err}, {27'd0, st, (st == 2'd2), 2'b00});
                if (k == 0 || (k == e2 - 1 && g < T)) begin
                    check("s_addr", s_addr, addr);
                    check("s_wdata", s_wdata, wdata);
                    check("s_cmd_sel", {30'd0, s_cmd, slave_sel}, {30'd0, cmd, addr[31]});
                end
                grant     = (g < T) && ((k == g) || (k > g && $urandom_range(0, 1) == 1));
                s_ack     = (k < e1 && $urandom_range(0, 1) == 1) || (g < T && a < T && k == e1 + a);
                data_read = (k < e2 && $urandom_range(0, 1) == 1) ||
                            (g < T && a < T && cmd == 1'b0 && d < T && k == e2 + d);
            end else begin
                grant = 1'b0; s_ack = 1'b0; data_read = 1'b0;
                m_req = keep;
                check("ack", {27'd0, stat, s_req, m_ack, m_err}, {27'd0, 2'd0, 1'b0, 1'b1, err});
                check("ack_rdata", m_rdata, exp_rd);
            end
        end
        step();
        check("post_ack", {27'd0, stat, s_req, m_ack, m_err}, 32'd0);
        check("post_rdata", m_rdata, 32'd0);
    endtask

    initial begin
        reset = 1'b0; m_req = 1'b0; m_cmd = 1'b0; m_addr = '0; m_wdata = '0;
        grant = 1'b0; s_ack = 1'b0; data_read = 1'b0; rdata_in = '0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b1;
        step();
        check_all_zero("idle");

        run_txn(1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 1'b0);
        run_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 32'h8000_0020, 32'h0000_A5A5, 32'h0, 1000, 0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 0, T - 1, 1'b0);
        run_txn(1'b1, 32'h8000_0030, 32'h5555_AAAA, 32'h0, T - 1, 1, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0040, 32'h0BAD_0BAD, 32'h0, 0, 300, 0, 1'b0);
        run_txn(1'b0, 32'h8000_0050, 32'h0, 32'h7777_7777, 2, 3, 300, 1'b0);
        run_txn(1'b1, 32'h0000_0060, 32'h1111_2222, 32'h0, 0, 0, 0, 1'b1);
        run_txn(1'b0, 32'h8000_0070, 32'h0, 32'h3333_4444, 1, 2, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)));
        end

        m_req = 1'b1; m_cmd = 1'b0; m_addr = 32'h8000_0100; rdata_in = 32'h9999_8888;
        step();
        check("rst_wgrant", {30'd0, stat}, 32'd1);
        grant = 1'b1;
        step();
        check("rst_wack", {30'd0, stat}, 32'd2);
        grant = 1'b0; s_ack = 1'b1;
        step();
        check("rst_wdata", {30'd0, stat}, 32'd3);
        s_ack = 1'b0;
        #2;
        reset = 1'b0; m_req = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        reset = 1'b1;
        data_read = 1'b1;
        step();
        data_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_ack", {27'd0, stat, s_req, m_ack, m_err}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
